// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and the load/store unit.
// Optional build macro MEM_ARB_RR_EN selects round-robin instead of LS priority.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif

module mem_port_arbiter #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [`ADDR_SIZE:0]  if_addr,
   output logic                 if_gnt,
   output logic                 if_valid,
   output logic [DATA_W-1:0]    if_rdata,
   input  logic                 ls_req,
   input  logic                 ls_we,
   input  logic [`ADDR_SIZE:0]  ls_addr,
   input  logic [DATA_W-1:0]    ls_wdata,
   output logic                 ls_gnt,
   output logic                 ls_valid,
   output logic [DATA_W-1:0]    ls_rdata,
   input  logic                 is_flush,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [`ADDR_SIZE:0]  mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ready,
   input  logic [DATA_W-1:0]    mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      LS_WAIT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [`ADDR_SIZE:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic                 if_gnt_q, if_gnt_d;
   logic                 ls_gnt_q, ls_gnt_d;
   logic                 if_valid_q, if_valid_d;
   logic                 ls_valid_q, ls_valid_d;
   logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]    ls_rdata_q, ls_rdata_d;
   logic                 drop_q, drop_d;

   logic                 if_ok;
   logic                 pick_if;
   logic                 pick_ls;

   assign if_ok = if_req & ~is_flush;

`ifdef MEM_ARB_RR_EN
   // Set when LS took the most recent grant; IF wins the next conflict.
   logic                 last_ls_q, last_ls_d;

   always_comb begin
      pick_ls = ls_req & (~if_ok | ~last_ls_q);
      pick_if = if_ok & ~pick_ls;
   end

   always_comb begin
      last_ls_d = last_ls_q;
      if (state_q == IDLE) begin
         if (pick_ls)      last_ls_d = 1'b1;
         else if (pick_if) last_ls_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_ls_q <= 1'b0;
      else       last_ls_q <= last_ls_d;
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]           streak_q, streak_d;
   logic                 force_if;

   always_comb begin
      force_if = if_ok & (streak_q >= LIMIT);
      pick_if  = if_ok & (~ls_req | force_if);
      pick_ls  = ls_req & ~pick_if;
   end

   // A flushed fetch can still bump the streak, so saturate rather than wrap.
   always_comb begin
      streak_d = streak_q;
      if (state_q == IDLE) begin
         if (pick_if || !if_req)
            streak_d = '0;
         else if (pick_ls && streak_q != 4'hF)
            streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) streak_q <= '0;
      else       streak_q <= streak_d;
   end
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_valid_d  = 1'b0;
      ls_valid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      drop_d      = drop_q;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (pick_ls) begin
               mem_req_d   = 1'b1;
               mem_we_d    = ls_we;
               mem_addr_d  = ls_addr;
               mem_wdata_d = ls_wdata;
               ls_gnt_d    = 1'b1;
               state_d     = LS_WAIT;
            end else if (pick_if) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               if_gnt_d    = 1'b1;
               state_d     = IF_WAIT;
            end else begin
               mem_req_d   = 1'b0;
            end
         end

         IF_WAIT: begin
            if (is_flush) drop_d = 1'b1;
            if (mem_ready) begin
               mem_req_d = 1'b0;
               drop_d    = 1'b0;
               state_d   = IDLE;
               if (!(drop_q || is_flush)) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end
         end

         LS_WAIT: begin
            if (mem_ready) begin
               mem_req_d  = 1'b0;
               ls_valid_d = 1'b1;
               ls_rdata_d = mem_we_q ? '0 : mem_rdata;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         ls_valid_q  <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_valid_q  <= if_valid_d;
         ls_valid_q  <= ls_valid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         drop_q      <= drop_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_valid  = if_valid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_gnt    = ls_gnt_q;
   assign ls_valid  = ls_valid_q;
   assign ls_rdata  = ls_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus multi-cycle corner sequences.

`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif

module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = `ADDR_SIZE + 1;
   localparam int SL = 4;
   localparam int OW = 6 + 3 * DW + AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_valid;
   logic [DW-1:0] if_rdata;
   logic          ls_req = 1'b0;
   logic          ls_we = 1'b0;
   logic [AW-1:0] ls_addr = '0;
   logic [DW-1:0] ls_wdata = '0;
   logic          ls_gnt, ls_valid;
   logic [DW-1:0] ls_rdata;
   logic          is_flush = 1'b0;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   mem_port_arbiter #(.DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
      .is_flush(is_flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ifr; logic [AW-1:0] ifa;
      logic lsr; logic lwe; logic [AW-1:0] lsa; logic [DW-1:0] wd;
      logic fl;  logic rdy; logic [DW-1:0] rd;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tv [0:31];
   int   nv = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic add(input logic ifr, input logic [AW-1:0] ifa,
                      input logic lsr, input logic lwe, input logic [AW-1:0] lsa, input logic [DW-1:0] wd,
                      input logic fl, input logic rdy, input logic [DW-1:0] rd,
                      input logic ig, input logic iv, input logic [DW-1:0] ird,
                      input logic lg, input logic lv, input logic [DW-1:0] lrd,
                      input logic mr, input logic mwe, input logic [AW-1:0] ma, input logic [DW-1:0] mwd);
      tv[nv].ifr = ifr; tv[nv].ifa = ifa;
      tv[nv].lsr = lsr; tv[nv].lwe = lwe; tv[nv].lsa = lsa; tv[nv].wd = wd;
      tv[nv].fl = fl; tv[nv].rdy = rdy; tv[nv].rd = rd;
      tv[nv].exp = {ig, iv, ird, lg, lv, lrd, mr, mwe, ma, mwd};
      nv++;
   endtask

   function automatic logic [OW-1:0] outs();
      return {if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata};
   endfunction

   task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ifr, input logic [AW-1:0] ifa, input logic lsr, input logic lwe,
                        input logic [AW-1:0] lsa, input logic [DW-1:0] wd,
                        input logic fl, input logic rdy, input logic [DW-1:0] rd);
      if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = lwe; ls_addr = lsa; ls_wdata = wd;
      is_flush = fl; mem_ready = rdy; mem_rdata = rd;
   endtask

   localparam logic [DW-1:0] DB = 32'hDEADBEEF;
   localparam logic [DW-1:0] CF = 32'hCAFEF00D;
   localparam logic [DW-1:0] V3 = 32'h33333333;
   localparam logic [DW-1:0] V4 = 32'h44444444;
   localparam logic [DW-1:0] V5 = 32'h55555555;

   initial begin
      int grants;
      logic exp_if;

      //    ifr ifa      lsr we lsa      wd        fl rdy rd              ig iv ird           lg lv lrd  mr we ma        mwd
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, 'h55,          0, 0, 0,  0, 0, 0,  0, 0, 'h00, 'h0000);
      add(1, 'h10, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, 0,  0, 0, 0,  1, 0, 'h10, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, DB,            0, 1, DB, 0, 0, 0,  0, 0, 'h10, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           0, 0, DB, 0, 0, 0,  0, 0, 'h10, 'h0000);
      add(0, 'h00, 1, 1, 'h40, 'h1234, 0, 0, 'h0,           0, 0, DB, 1, 0, 0,  1, 1, 'h40, 'h1234);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           0, 0, DB, 0, 0, 0,  1, 1, 'h40, 'h1234);
      add(1, 'h20, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           0, 0, DB, 0, 0, 0,  1, 1, 'h40, 'h1234);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           0, 0, DB, 0, 0, 0,  1, 1, 'h40, 'h1234);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, 'hAAAA,        0, 0, DB, 0, 1, 0,  0, 1, 'h40, 'h1234);
      add(0, 'h00, 1, 0, 'h44, 'h0000, 0, 0, 'h0,           0, 0, DB, 1, 0, 0,  1, 0, 'h44, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, CF,            0, 0, DB, 0, 1, CF, 0, 0, 'h44, 'h0000);
      add(1, 'h80, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, DB, 0, 0, CF, 1, 0, 'h80, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 1, 0, 'h0,           0, 0, DB, 0, 0, CF, 1, 0, 'h80, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, 'h11111111,    0, 0, DB, 0, 0, CF, 0, 0, 'h80, 'h0000);
      add(1, 'h84, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, DB, 0, 0, CF, 1, 0, 'h84, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 1, 1, 'h22222222,    0, 0, DB, 0, 0, CF, 0, 0, 'h84, 'h0000);
      add(1, 'h88, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, DB, 0, 0, CF, 1, 0, 'h88, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, V3,            0, 1, V3, 0, 0, CF, 0, 0, 'h88, 'h0000);
      add(1, 'h90, 1, 0, 'h48, 'h0000, 1, 0, 'h0,           0, 0, V3, 1, 0, CF, 1, 0, 'h48, 'h0000);
      add(1, 'h90, 0, 0, 'h00, 'h0000, 0, 1, V4,            0, 0, V3, 0, 1, V4, 0, 0, 'h48, 'h0000);
      add(1, 'h90, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, V3, 0, 0, V4, 1, 0, 'h90, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, V5,            0, 1, V5, 0, 0, V4, 0, 0, 'h90, 'h0000);
      add(1, 'hA0, 1, 1, 'h4C, 'hBEEF, 0, 0, 'h0,           0, 0, V5, 1, 0, V4, 1, 1, 'h4C, 'hBEEF);
      add(1, 'hA0, 0, 0, 'h00, 'h0000, 0, 1, 'h66666666,    0, 0, V5, 0, 1, 0,  0, 1, 'h4C, 'hBEEF);
      add(1, 'hA0, 0, 0, 'h00, 'h0000, 0, 0, 'h0,           1, 0, V5, 0, 0, 0,  1, 0, 'hA0, 'h0000);
      add(0, 'h00, 0, 0, 'h00, 'h0000, 0, 1, 'h77777777,    0, 1, 'h77777777, 0, 0, 0, 0, 0, 'hA0, 'h0000);

      step();
      step();
      check("reset_outputs", outs(), '0);
      reset = 1'b0;

      for (int i = 0; i < nv; i++) begin
         drive(tv[i].ifr, tv[i].ifa, tv[i].lsr, tv[i].lwe, tv[i].lsa, tv[i].wd, tv[i].fl, tv[i].rdy, tv[i].rd);
         step();
         check($sformatf("vec%0d", i), outs(), tv[i].exp);
      end

      // Both sides request continuously against a 1-cycle memory.
      drive(1, 'hC0, 1, 0, 'hD0, '0, 0, 1, '0);
      grants = 0;
      for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
         step();
         if (if_gnt || ls_gnt) begin
`ifdef MEM_ARB_RR_EN
            exp_if = (grants % 2) == 1;
`else
            exp_if = (grants % (SL + 1)) == SL;
`endif
            check($sformatf("order%0d", grants), OW'({if_gnt, ls_gnt}), OW'({exp_if, ~exp_if}));
            grants++;
         end
      end
      if (grants < 10) check("order_timeout", OW'(grants), OW'(10));
      drive(0, '0, 0, 0, '0, '0, 0, 1, '0);
      step();
      step();
      mem_ready = 1'b0;
      step();

      // Asynchronous reset while a store is outstanding.
      drive(0, '0, 1, 1, 'h60, 'h99, 0, 0, '0);
      step();
      check("rst_pre_gnt", OW'({ls_gnt, mem_req, mem_we}), OW'(3'b111));
      ls_req = 1'b0;
      step();
      check("rst_pre_wait", OW'({ls_gnt, mem_req}), OW'(2'b01));
      #2 reset = 1'b1;
      #1 check("rst_async", outs(), '0);
      step();
      reset = 1'b0;
      check("rst_hold", outs(), '0);

      // First conflict after reset goes to LS in either arbitration mode.
      drive(1, 'hE0, 1, 0, 'hE4, '0, 0, 0, '0);
      step();
      check("post_rst_conflict", outs(), {1'b0, 1'b0, DW'(0), 1'b1, 1'b0, DW'(0), 1'b1, 1'b0, AW'('hE4), DW'(0)});
      drive(1, 'hE0, 0, 0, '0, '0, 0, 1, 32'h0BADF00D);
      step();
      check("post_rst_load", OW'({ls_valid, ls_rdata, mem_req}), OW'({1'b1, 32'h0BADF00D, 1'b0}));
      drive(1, 'hE0, 0, 0, '0, '0, 0, 0, '0);
      step();
      check("post_rst_if_gnt", OW'({if_gnt, mem_req, mem_addr}), OW'({1'b1, 1'b1, AW'('hE0)}));
      drive(0, '0, 0, 0, '0, '0, 0, 1, 32'h12345678);
      step();
      check("post_rst_if_valid", OW'({if_valid, if_rdata, mem_req}), OW'({1'b1, 32'h12345678, 1'b0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
